// File: rtl/dcache.sv
// Direct-mapped, write-back data cache with two-word blocks.
// Misses write back a dirty victim before refilling; halt writes back every dirty set.
module dcache #(
  parameter int unsigned SETS     = 16,
  parameter int unsigned BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = 32 - IdxW - 3;

  if (BLKWORDS != 2 || SETS < 2) begin : g_param_check
    $error("dcache supports only BLKWORDS == 2 and SETS >= 2");
  end

  typedef enum logic [3:0] {
    StIdle, StWb0, StWb1, StLd0, StLd1, StFlush0, StFlush1, StFlushNext, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   fidx_q, fidx_d;
  logic [SETS-1:0]   valid_q, dirty_q;
  logic [TagW-1:0]   tag_q   [SETS];
  logic [31:0]       word0_q [SETS];
  logic [31:0]       word1_q [SETS];

  logic [TagW-1:0] req_tag;
  logic [IdxW-1:0] req_idx;
  logic            req_off, req, hit;
  logic            wr_hit, ld0_done, ld1_done, clr_dirty;
  logic            unused_byte;

  assign req_tag     = dmemaddr[31:IdxW+3];
  assign req_idx     = dmemaddr[IdxW+2:3];
  assign req_off     = dmemaddr[2];
  assign unused_byte = ^dmemaddr[1:0];
  assign req         = dmemREN | dmemWEN;
  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d   = state_q;
    fidx_d    = fidx_q;
    dhit      = 1'b0;
    dmemload  = '0;
    flushed   = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    wr_hit    = 1'b0;
    ld0_done  = 1'b0;
    ld1_done  = 1'b0;
    clr_dirty = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StFlush0;
          fidx_d  = '0;
        end else if (req) begin
          if (hit) begin
            dhit     = 1'b1;
            dmemload = req_off ? word1_q[req_idx] : word0_q[req_idx];
            // Simultaneous read and write requests are served as a write.
            wr_hit   = dmemWEN;
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = StWb0;
          end else begin
            state_d = StLd0;
          end
        end
      end
      StWb0: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 3'b000};
        dstore = word0_q[req_idx];
        if (!dwait) state_d = StWb1;
      end
      StWb1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 3'b100};
        dstore = word1_q[req_idx];
        if (!dwait) state_d = StLd0;
      end
      StLd0: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 3'b000};
        if (!dwait) begin
          ld0_done = 1'b1;
          state_d  = StLd1;
        end
      end
      StLd1: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 3'b100};
        if (!dwait) begin
          ld1_done = 1'b1;
          state_d  = StIdle;
        end
      end
      StFlush0: begin
        if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
          dWEN   = 1'b1;
          daddr  = {tag_q[fidx_q], fidx_q, 3'b000};
          dstore = word0_q[fidx_q];
          if (!dwait) state_d = StFlush1;
        end else begin
          state_d = StFlushNext;
        end
      end
      StFlush1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[fidx_q], fidx_q, 3'b100};
        dstore = word1_q[fidx_q];
        if (!dwait) state_d = StFlushNext;
      end
      StFlushNext: begin
        clr_dirty = 1'b1;
        if (fidx_q == IdxW'(SETS - 1)) begin
          state_d = StDone;
        end else begin
          fidx_d  = fidx_q + IdxW'(1);
          state_d = StFlush0;
        end
      end
      StDone: flushed = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StIdle;
      fidx_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      if (wr_hit) dirty_q[req_idx] <= 1'b1;
      if (ld1_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (clr_dirty) dirty_q[fidx_q] <= 1'b0;
    end
  end

  // Data and tag arrays carry no reset; valid_q gates every use of them.
  always_ff @(posedge CLK) begin
    if (wr_hit && !req_off) word0_q[req_idx] <= dmemstore;
    if (wr_hit && req_off)  word1_q[req_idx] <= dmemstore;
    if (ld0_done) word0_q[req_idx] <= dload;
    if (ld1_done) begin
      word1_q[req_idx] <= dload;
      tag_q[req_idx]   <= req_tag;
    end
  end

endmodule
